// File: rtl/alu_arb.sv
// alu_arb: two-requester round-robin front end for a single shared ALU.
// One operation in flight: IDLE (arbitrate) -> EXEC (alu_en) -> FLAG (grab
// registered flags) -> RESP (hold response until consumed).
module alu_arb #(
    parameter int W   = 32,
    parameter int OPW = 4,
    parameter int FW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           r0_valid,
    output logic           r0_ready,
    input  logic [W-1:0]   r0_op1,
    input  logic [W-1:0]   r0_op2,
    input  logic [OPW-1:0] r0_oprt,
    input  logic           r1_valid,
    output logic           r1_ready,
    input  logic [W-1:0]   r1_op1,
    input  logic [W-1:0]   r1_op2,
    input  logic [OPW-1:0] r1_oprt,
    output logic [W-1:0]   alu_op1,
    output logic [W-1:0]   alu_op2,
    output logic [OPW-1:0] alu_oprt,
    output logic           alu_en,
    input  logic [W-1:0]   alu_res,
    input  logic [10:0]    alu_flag,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_res,
    output logic [FW-1:0]  rsp_flag
);

    typedef enum logic [1:0] {IDLE, EXEC, FLAG, RESP} state_t;

    state_t state, state_nxt;
    logic   last_id;   // requester granted most recently; 1 after reset so r0 goes first
    logic   grant0, grant1;
    logic   unused_flag;

    // Only the low FW flag bits are returned; the rest of the ALU flag bus is ignored.
    assign unused_flag = &{1'b0, alu_flag};

    // Combinational round-robin arbitration, only while idle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (r0_valid && (!r1_valid || last_id))
                grant0 = 1'b1;
            else if (r1_valid)
                grant1 = 1'b1;
        end
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        alu_en    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: if (grant0 || grant1) state_nxt = EXEC;
            EXEC: begin
                alu_en    = 1'b1;
                state_nxt = FLAG;
            end
            FLAG: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch on grant, result capture in EXEC, flag capture in FLAG.
    // alu_res is undriven outside EXEC, so it is only ever sampled there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_op1  <= '0;
            alu_op2  <= '0;
            alu_oprt <= '0;
            rsp_id   <= 1'b0;
            rsp_res  <= '0;
            rsp_flag <= '0;
            last_id  <= 1'b1;
        end else begin
            if (grant0 || grant1) begin
                alu_op1  <= grant1 ? r1_op1  : r0_op1;
                alu_op2  <= grant1 ? r1_op2  : r0_op2;
                alu_oprt <= grant1 ? r1_oprt : r0_oprt;
                rsp_id   <= grant1;
                last_id  <= grant1;
            end
            if (state == EXEC) rsp_res  <= alu_res;
            if (state == FLAG) rsp_flag <= alu_flag[FW-1:0];
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: randomized and directed checks of alu_arb against a simple
// ALU stand-in and a cycle-timeline reference model.
module tb_alu_arb;
    localparam int W = 32, OPW = 4, FW = 4;

    logic           clk = 1'b0, rst = 1'b0;
    logic           r0_valid = 1'b0, r1_valid = 1'b0, r0_ready, r1_ready;
    logic [W-1:0]   r0_op1 = '0, r0_op2 = '0, r1_op1 = '0, r1_op2 = '0;
    logic [OPW-1:0] r0_oprt = '0, r1_oprt = '0;
    logic [W-1:0]   alu_op1, alu_op2, alu_res;
    logic [OPW-1:0] alu_oprt;
    logic           alu_en;
    logic [10:0]    alu_flag = '0;
    logic           rsp_valid, rsp_ready = 1'b1, rsp_id;
    logic [W-1:0]   rsp_res;
    logic [FW-1:0]  rsp_flag;
    logic [FW+W-1:0] alu_out;

    int chk_cnt = 0, pass_cnt = 0;

    alu_arb #(.W(W), .OPW(OPW), .FW(FW)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op1(r0_op1), .r0_op2(r0_op2), .r0_oprt(r0_oprt),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op1(r1_op1), .r1_op2(r1_op2), .r1_oprt(r1_oprt),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oprt(alu_oprt), .alu_en(alu_en),
        .alu_res(alu_res), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flag(rsp_flag)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {V,C,Z,N,result}. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, else pass op1.
    function automatic logic [FW+W-1:0] alu_calc(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0; v = 1'b0; s = '0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[W-1:0]; c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {v, c, (r == '0), r[W-1], r};
    endfunction

    // ALU stand-in: junk on res when disabled (stands in for high-Z), flags
    // registered on the EXEC edge and scrambled on every other edge.
    assign alu_out = alu_calc(alu_oprt, alu_op1, alu_op2);
    assign alu_res = alu_en ? alu_out[W-1:0] : 32'hDEAD_BEEF;
    always @(posedge clk) alu_flag <= alu_en ? {7'($urandom), alu_out[W+:FW]} : 11'($urandom);

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
        tick;
        rst = 1'b1;
    endtask

    // Drives one operation from requester id and waits for its response (no checking here
    // except for expired waits).
    task automatic run_one(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int en_cnt, output bit en_first, output bit rdy_after,
                           output bit rid, output logic [31:0] res, output logic [3:0] flg);
        int t;
        lat = -1; en_cnt = 0; en_first = 1'b0; rdy_after = 1'b0; rid = 1'b0; res = '0; flg = '0;
        if (id) begin r1_valid = 1'b1; r1_op1 = a; r1_op2 = b; r1_oprt = op; end
        else    begin r0_valid = 1'b1; r0_op1 = a; r0_op2 = b; r0_oprt = op; end
        #1;
        t = 0;
        while (!(id ? r1_ready : r0_ready) && t < 20) begin tick; t++; end
        if (t >= 20) begin
            chk_cnt++; $display("FAIL grant_timeout id=%0d waited=%0d cycles", id, t);
            r0_valid = 1'b0; r1_valid = 1'b0; return;
        end
        tick;
        rdy_after = id ? r1_ready : r0_ready;
        r0_valid = 1'b0; r1_valid = 1'b0;
        en_first = alu_en;
        lat = 1;
        while (!rsp_valid && lat < 20) begin en_cnt += int'(alu_en); tick; lat++; end
        en_cnt += int'(alu_en);
        if (lat >= 20) begin chk_cnt++; $display("FAIL rsp_timeout id=%0d", id); return; end
        rid = rsp_id; res = rsp_res; flg = rsp_flag;
    endtask

    task automatic test_reset;
        pulse_reset;
        rst = 1'b0; tick; #1;
        chk_cnt++; if (alu_en !== 1'b0)    $display("FAIL reset_alu_en got=%b exp=0", alu_en);       else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else pass_cnt++;
        chk_cnt++; if ({alu_op1, alu_op2, alu_oprt} !== '0) $display("FAIL reset_alu_ops got=%h/%h/%h exp=0", alu_op1, alu_op2, alu_oprt); else pass_cnt++;
        chk_cnt++; if ({rsp_res, rsp_flag, rsp_id} !== '0) $display("FAIL reset_rsp got=%h/%h/%b exp=0", rsp_res, rsp_flag, rsp_id); else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_add;
        int lat, en_cnt; bit en_first, rdy_after, rid; logic [31:0] res; logic [3:0] flg;
        run_one(1'b0, 4'd0, 32'd5, 32'd3, lat, en_cnt, en_first, rdy_after, rid, res, flg);
        chk_cnt++; if (rdy_after !== 1'b0) $display("FAIL add_ready_1cyc got=%b exp=0", rdy_after); else pass_cnt++;
        chk_cnt++; if (en_first !== 1'b1)  $display("FAIL add_en_after_accept got=%b exp=1", en_first); else pass_cnt++;
        chk_cnt++; if (en_cnt != 1)        $display("FAIL add_en_cycles got=%0d exp=1", en_cnt); else pass_cnt++;
        chk_cnt++; if (lat != 3)           $display("FAIL add_latency got=%0d exp=3", lat); else pass_cnt++;
        chk_cnt++; if ({rid, res, flg} !== {1'b0, 32'h0000_0008, 4'b0000}) $display("FAIL add_rsp got=%b/%h/%b exp=0/00000008/0000", rid, res, flg); else pass_cnt++;
        tick;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL add_rsp_drop got=%b exp=0", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_sub;
        int lat, en_cnt; bit en_first, rdy_after, rid; logic [31:0] res; logic [3:0] flg;
        run_one(1'b1, 4'd1, 32'd3, 32'd5, lat, en_cnt, en_first, rdy_after, rid, res, flg);
        chk_cnt++; if ({rid, res, flg} !== {1'b1, 32'hFFFF_FFFE, 4'b0001}) $display("FAIL sub_neg got=%b/%h/%b exp=1/fffffffe/0001", rid, res, flg); else pass_cnt++;
        tick;
        run_one(1'b1, 4'd1, 32'd5, 32'd5, lat, en_cnt, en_first, rdy_after, rid, res, flg);
        chk_cnt++; if ({rid, res, flg} !== {1'b1, 32'h0, 4'b0110}) $display("FAIL sub_zero got=%b/%h/%b exp=1/00000000/0110", rid, res, flg); else pass_cnt++;
        tick;
    endtask

    task automatic test_overflow;
        int lat, en_cnt; bit en_first, rdy_after, rid; logic [31:0] res; logic [3:0] flg;
        run_one(1'b0, 4'd0, 32'h7FFF_FFFF, 32'd1, lat, en_cnt, en_first, rdy_after, rid, res, flg);
        chk_cnt++; if ({rid, res, flg} !== {1'b0, 32'h8000_0000, 4'b1001}) $display("FAIL add_ovf got=%b/%h/%b exp=0/80000000/1001", rid, res, flg); else pass_cnt++;
        tick;
    endtask

    task automatic test_back_to_back;
        bit               exp_id[$];
        logic [FW+W-1:0]  exp_val[$];
        bit               gid[4];
        int               gcyc[4];
        int               gcnt, rcnt, g;
        pulse_reset;
        r0_valid = 1'b1; r0_op1 = $urandom; r0_op2 = $urandom; r0_oprt = 4'($urandom_range(0, 4));
        r1_valid = 1'b1; r1_op1 = $urandom; r1_op2 = $urandom; r1_oprt = 4'($urandom_range(0, 4));
        gcnt = 0; rcnt = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            g = -1;
            if (rsp_valid) begin
                if (exp_id.size() == 0) begin
                    chk_cnt++; $display("FAIL b2b_extra_rsp cycle=%0d id=%b", c, rsp_id);
                end else begin
                    chk_cnt++;
                    if ({rsp_id, rsp_flag, rsp_res} !== {exp_id[0], exp_val[0]})
                        $display("FAIL b2b_rsp cycle=%0d got=%b/%b/%h exp=%b/%b/%h", c, rsp_id, rsp_flag, rsp_res, exp_id[0], exp_val[0][W+:FW], exp_val[0][W-1:0]);
                    else pass_cnt++;
                    void'(exp_id.pop_front()); void'(exp_val.pop_front());
                end
                rcnt++;
            end
            if (r0_ready || r1_ready) begin
                g = r1_ready ? 1 : 0;
                if (gcnt < 4) begin gid[gcnt] = r1_ready; gcyc[gcnt] = c; end
                exp_id.push_back(r1_ready);
                exp_val.push_back(r1_ready ? alu_calc(r1_oprt, r1_op1, r1_op2) : alu_calc(r0_oprt, r0_op1, r0_op2));
                gcnt++;
            end
            tick;
            if (g == 0) begin r0_op1 = $urandom; r0_op2 = $urandom; r0_oprt = 4'($urandom_range(0, 4)); end
            if (g == 1) begin r1_op1 = $urandom; r1_op2 = $urandom; r1_oprt = 4'($urandom_range(0, 4)); end
            if (gcnt >= 4) begin r0_valid = 1'b0; r1_valid = 1'b0; end
        end
        #1;
        chk_cnt++; if (gcnt != 4 || rcnt != 4) $display("FAIL b2b_counts grants=%0d rsps=%0d exp=4/4", gcnt, rcnt); else pass_cnt++;
        chk_cnt++; if ({gid[0], gid[1], gid[2], gid[3]} !== 4'b0101) $display("FAIL b2b_order got=%b%b%b%b exp=0101", gid[0], gid[1], gid[2], gid[3]); else pass_cnt++;
        chk_cnt++; if (gcyc[0] != 0 || gcyc[1] != 4 || gcyc[2] != 8 || gcyc[3] != 12) $display("FAIL b2b_spacing got=%0d,%0d,%0d,%0d exp=0,4,8,12", gcyc[0], gcyc[1], gcyc[2], gcyc[3]); else pass_cnt++;
        chk_cnt++; if (rsp_valid !== 1'b0 || alu_en !== 1'b0) $display("FAIL b2b_end_idle got=%b/%b exp=0/0", rsp_valid, alu_en); else pass_cnt++;
    endtask

    task automatic test_stall;
        int lat, en_cnt; bit en_first, rdy_after, rid; logic [31:0] res, a, b; logic [3:0] flg;
        logic [FW+W-1:0] e;
        a = $urandom; b = $urandom;
        e = alu_calc(4'd4, a, b);
        rsp_ready = 1'b0;
        run_one(1'b0, 4'd4, a, b, lat, en_cnt, en_first, rdy_after, rid, res, flg);
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick; #1;
            chk_cnt++;
            if ({rsp_valid, rsp_id, rsp_flag, rsp_res, r0_ready, r1_ready} !== {1'b1, 1'b0, e, 2'b00})
                $display("FAIL stall_hold cyc=%0d got v=%b id=%b f=%b r=%h rdy=%b%b exp v=1 id=0 f=%b r=%h rdy=00",
                         i, rsp_valid, rsp_id, rsp_flag, rsp_res, r0_ready, r1_ready, e[W+:FW], e[W-1:0]);
            else pass_cnt++;
        end
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
        tick;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL stall_release got=%b exp=0", rsp_valid); else pass_cnt++;
        tick; tick; tick;
        chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL stall_single_rsp got=%b exp=0", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int lat, en_cnt; bit en_first, rdy_after, rid; logic [31:0] res; logic [3:0] flg;
        run_one(1'b1, 4'd0, 32'h1234_0000, 32'h0000_5678, lat, en_cnt, en_first, rdy_after, rid, res, flg);
        tick;
        r0_valid = 1'b1; r0_op1 = 32'hA5A5_A5A5; r0_op2 = 32'h5A5A_5A5A; r0_oprt = 4'd3;
        #1;
        chk_cnt++; if (r0_ready !== 1'b1) $display("FAIL rmid_accept got=%b exp=1", r0_ready); else pass_cnt++;
        tick;                // accepted, now EXEC
        r0_valid = 1'b0;
        tick;                // FLAG
        rst = 1'b0;
        tick; #1;
        chk_cnt++; if ({rsp_valid, alu_en} !== 2'b00) $display("FAIL rmid_ctrl got=%b/%b exp=0/0", rsp_valid, alu_en); else pass_cnt++;
        chk_cnt++; if ({alu_op1, alu_op2, alu_oprt, rsp_res, rsp_flag, rsp_id} !== '0)
            $display("FAIL rmid_clear got=%h/%h/%h/%h/%h/%b exp=0", alu_op1, alu_op2, alu_oprt, rsp_res, rsp_flag, rsp_id); else pass_cnt++;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rmid_no_rsp cyc=%0d got=%b exp=0", i, rsp_valid); else pass_cnt++;
        end
        r0_valid = 1'b1; r1_valid = 1'b1; r0_oprt = 4'd0; r0_op1 = 32'd1; r0_op2 = 32'd1;
        #1;
        chk_cnt++; if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL rmid_r0_first got=%b%b exp=10", r0_ready, r1_ready); else pass_cnt++;
        tick;
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick; tick;
        chk_cnt++; if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b0, 32'd2}) $display("FAIL rmid_after got=%b/%b/%h exp=1/0/00000002", rsp_valid, rsp_id, rsp_res); else pass_cnt++;
        tick;
    endtask

    // Random traffic against a timeline model: a grant at cycle c puts alu_en at c+1
    // and the response on from c+3 until consumed; requests are granted only while no
    // operation is outstanding, and on contention the requester not granted last wins.
    task automatic test_random;
        bit              busy, last_g, exp_r0, exp_r1, w;
        int              due;
        bit              q_id[$];
        logic [FW+W-1:0] q_val[$];
        pulse_reset;
        busy = 1'b0; last_g = 1'b1; due = 0;
        for (int c = 0; c < 300; c++) begin
            r0_valid = ($urandom_range(0, 2) != 0);
            r1_valid = ($urandom_range(0, 2) != 0);
            r0_op1 = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom; r0_op2 = $urandom; r0_oprt = 4'($urandom_range(0, 5));
            r1_op1 = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom; r1_op2 = $urandom; r1_oprt = 4'($urandom_range(0, 5));
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_r0 = 1'b0; exp_r1 = 1'b0; w = 1'b0;
            if (!busy && (r0_valid || r1_valid)) begin
                w = (r0_valid && r1_valid) ? ~last_g : r1_valid;
                if (w) exp_r1 = 1'b1; else exp_r0 = 1'b1;
            end
            chk_cnt++; if ({r0_ready, r1_ready} !== {exp_r0, exp_r1}) $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", c, r0_ready, r1_ready, exp_r0, exp_r1); else pass_cnt++;
            chk_cnt++; if (alu_en !== (busy && c == due - 2)) $display("FAIL rnd_alu_en cyc=%0d got=%b exp=%b", c, alu_en, busy && c == due - 2); else pass_cnt++;
            chk_cnt++; if (rsp_valid !== (busy && c >= due)) $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, busy && c >= due); else pass_cnt++;
            if (busy && c >= due && q_id.size() > 0) begin
                chk_cnt++;
                if ({rsp_id, rsp_flag, rsp_res} !== {q_id[0], q_val[0]})
                    $display("FAIL rnd_rsp cyc=%0d got=%b/%b/%h exp=%b/%b/%h", c, rsp_id, rsp_flag, rsp_res, q_id[0], q_val[0][W+:FW], q_val[0][W-1:0]);
                else pass_cnt++;
                if (rsp_ready) begin void'(q_id.pop_front()); void'(q_val.pop_front()); busy = 1'b0; end
            end
            if (exp_r0 || exp_r1) begin
                busy = 1'b1; due = c + 3; last_g = w;
                q_id.push_back(w);
                q_val.push_back(w ? alu_calc(r1_oprt, r1_op1, r1_op2) : alu_calc(r0_oprt, r0_op1, r0_op2));
            end
            tick;
        end
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
        tick; tick; tick; tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_overflow;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Sequencer and round-robin arbiter that shares one ALU instance between two requesters, e.g. the execute stage (requester 0) and the address/branch unit (requester 1).
- Accepts an operation over valid/ready and drives the ALU operand, opcode and enable lines for exactly one cycle.
- Captures the combinational result that cycle, then the registered flags the next cycle.
- Returns result, flags and requester id over a valid/ready response channel.

Parameters:
- W, 32, operand/result width; must match the ALU datapath.
- OPW, 4, opcode width.
- FW, 4, number of low ALU flag bits returned: bit 0 N, bit 1 Z, bit 2 C, bit 3 V.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- r0_valid  in  1  requester 0 has an operation
- r0_ready  out  1  requester 0 operation accepted this cycle
- r0_op1, r0_op2  in  W  requester 0 operands
- r0_oprt  in  OPW  requester 0 opcode
- r1_valid, r1_ready, r1_op1, r1_op2, r1_oprt: same set for requester 1
- alu_op1, alu_op2  out  W  to ALU op1/op2
- alu_oprt  out  OPW  to ALU oprt
- alu_en  out  1  to ALU en
- alu_res  in  W  from ALU res; high-Z whenever alu_en=0
- alu_flag  in  11  from ALU flag; registered inside the ALU on the same clk
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_res  out  W  captured result
- rsp_flag  out  FW  captured alu_flag[FW-1:0]

Behaviour:
- FSM states: IDLE, EXEC, FLAG, RESP. Exactly one operation in flight. Minimum 4 cycles per operation, IDLE to IDLE.
- Reset (rst=0 at posedge):
  - State goes to IDLE and rsp_valid=0.
  - alu_en=0; alu_op1, alu_op2, alu_oprt, rsp_res, rsp_flag and rsp_id all clear to 0.
  - Round-robin pointer is set so requester 0 has priority first.
  - Reset mid-operation silently drops the operation and produces no response.
- IDLE:
  - Arbitration is combinational. Ready is asserted only to the winner, only in IDLE, and only while the winner's valid is high. r0_ready and r1_ready are never both 1.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not granted last wins. After reset, r0 wins.
  - On a handshake: latch op1/op2/oprt into the alu_* output registers, record rsp_id, update the pointer to the winner, go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - alu_en=1 for this single cycle.
  - At the clock edge, rsp_res captures alu_res. Go to FLAG.
- FLAG:
  - alu_en=0.
  - alu_flag now reflects the EXEC-cycle result, because the ALU registered it at the EXEC edge.
  - rsp_flag captures alu_flag[FW-1:0]. Go to RESP.
  - alu_res is high-Z in this state and must not be sampled.
- RESP:
  - rsp_valid=1. rsp_id, rsp_res and rsp_flag stay stable until the handshake.
  - When rsp_ready=1, go to IDLE; rsp_valid is 0 from the next cycle.
  - No request is accepted in RESP. This holds even when rsp_ready=1, so there is no bypass.
  - rsp_ready held low stalls the block indefinitely; both ready outputs stay 0.
- alu_op1, alu_op2 and alu_oprt hold their last values outside EXEC. alu_en is 1 only in EXEC.
- Flags pass through without interpretation. C and V are meaningful only for opcodes 0000 (ADD) and 0001 (SUB).
- A requester that drops valid before getting ready loses nothing. Operands are sampled only on the handshake cycle.

Test Plan:
- r0: ADD, op1=5, op2=3 -> r0_ready for 1 cycle; alu_en high exactly one cycle later; 3 cycles after acceptance rsp_valid=1, rsp_id=0, rsp_res=0x00000008, rsp_flag=4'b0000.
- r1: SUB, op1=3, op2=5 -> rsp_id=1, rsp_res=0xFFFFFFFE, rsp_flag=4'b0001. Then SUB, op1=5, op2=5 -> rsp_res=0, rsp_flag=4'b0110 (Z=1, C=1).
- r0: ADD, op1=0x7FFFFFFF, op2=1 -> rsp_res=0x80000000, rsp_flag=4'b1001 (N=1, V=1).
- Both valid continuously for 4 operations with rsp_ready=1 -> grant order r0, r1, r0, r1; ready never asserted in EXEC/FLAG/RESP; 16 cycles total.
- rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_res, rsp_flag and rsp_id stable throughout; no readies asserted; one response only, after rsp_ready rises.
- rst=0 asserted during FLAG -> next cycle IDLE, rsp_valid=0, alu_en=0, outputs 0. With both requesters valid afterwards, r0 wins first.
